// File: rtl/mux8_pkg.sv
// Shared types and helpers for the 8-channel mux select scheduler.
package mux8_pkg;

  localparam int NumCh = 8;
  localparam int SelW  = 3;

  typedef logic [SelW-1:0]  sel_t;
  typedef logic [NumCh-1:0] ch_vec_t;

  // One-hot channel vector with only bit s set.
  function automatic ch_vec_t onehot8(input sel_t s);
    ch_vec_t v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating priority encoder: finds the first eligible channel at or above ptr,
// wrapping from channel 7 back to channel 0.
module rr_pick8
  import mux8_pkg::*;
(
  input  ch_vec_t elig,
  input  sel_t    ptr,
  output logic    found,
  output sel_t    idx
);

  // Scan the eight positions starting at ptr; 3-bit addition provides the wrap.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < NumCh; i++) begin
      if (!found && elig[ptr + sel_t'(i)]) begin
        found = 1'b1;
        idx   = ptr + sel_t'(i);
      end
    end
  end

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin select scheduler feeding the registered 8:1 data mux.
// The grant stage drives sel_o/ack_o; one cycle later, the output stage raises
// y_valid_o/y_ch_o, in step with the mux output register.
module mux8_rr_sched
  import mux8_pkg::*;
#(
  parameter int CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  ch_vec_t         req_i,
  input  ch_vec_t         mask_i,
  input  logic            ready_i,
  output sel_t            sel_o,
  output ch_vec_t         ack_o,
  output logic            y_valid_o,
  output sel_t            y_ch_o,
  output logic            overrun_o,
  output logic [CntW-1:0] grant_cnt_o
);

  ch_vec_t         pend_q, pend_d;
  sel_t            ptr_q, ptr_d;
  sel_t            sel_q, sel_d;
  ch_vec_t         ack_q, ack_d;
  logic            y_valid_q, y_valid_d;
  sel_t            y_ch_q, y_ch_d;
  logic            overrun_q, overrun_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  ch_vec_t elig;
  logic    pick_found;
  sel_t    pick_idx;
  logic    grant;
  ch_vec_t gnt_vec;

  // Only pending, unmasked channels compete; mask never touches pend.
  assign elig = pend_q & ~mask_i;

  rr_pick8 u_pick (
    .elig  (elig),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Grant stage: decide this cycle's winner and update pending, pointer and counter.
  always_comb begin
    grant     = en_i & ready_i & pick_found;
    gnt_vec   = grant ? onehot8(pick_idx) : '0;
    pend_d    = (pend_q & ~gnt_vec) | req_i;
    overrun_d = |(req_i & pend_q & ~gnt_vec);
    ptr_d     = grant ? pick_idx + sel_t'(1) : ptr_q;
    sel_d     = grant ? pick_idx : sel_q;
    ack_d     = gnt_vec;
    cnt_d     = cnt_q;
    if (grant && (cnt_q != '1)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Output stage: delayed copy of the previous cycle's grant, aligned with the mux register.
  always_comb begin
    y_valid_d = |ack_q;
    y_ch_d    = y_valid_d ? sel_q : y_ch_q;
  end

  // All scheduler state; asynchronous reset drops pending work and in-flight tags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q    <= '0;
      ptr_q     <= '0;
      sel_q     <= '0;
      ack_q     <= '0;
      y_valid_q <= 1'b0;
      y_ch_q    <= '0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pend_q    <= pend_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      y_valid_q <= y_valid_d;
      y_ch_q    <= y_ch_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sel_o       = sel_q;
  assign ack_o       = ack_q;
  assign y_valid_o   = y_valid_q;
  assign y_ch_o      = y_ch_q;
  assign overrun_o   = overrun_q;
  assign grant_cnt_o = cnt_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Self-checking bench for mux8_rr_sched; expected channel tags are queued as
// stimulus is driven and popped when y_valid_o appears.
module tb_mux8_rr_sched;

  localparam int CntW = 4;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic            ready;
  logic [7:0]      req;
  logic [7:0]      mask;
  logic [2:0]      sel;
  logic [7:0]      ack;
  logic            y_valid;
  logic [2:0]      y_ch;
  logic            overrun;
  logic [CntW-1:0] cnt;

  int n_cmp   = 0;
  int n_err   = 0;
  int exp_cnt = 0;
  int mon_exp = 0;
  int exp_q[$];

  mux8_rr_sched #(.CntW(CntW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .req_i       (req),
    .mask_i      (mask),
    .ready_i     (ready),
    .sel_o       (sel),
    .ack_o       (ack),
    .y_valid_o   (y_valid),
    .y_ch_o      (y_ch),
    .overrun_o   (overrun),
    .grant_cnt_o (cnt)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: every valid output word must match the oldest expected channel.
  always @(negedge clk) begin
    if (rst_n && y_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("[TB] FAIL sb_unexpected: y_valid_o=1 y_ch_o=%0d but no grant expected", y_ch);
      end else begin
        mon_exp = exp_q.pop_front();
        if (y_ch !== 3'(mon_exp)) begin
          n_err++;
          $display("[TB] FAIL sb_y_ch: got %0d expected %0d", y_ch, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic note_grant(input int ch);
    exp_q.push_back(ch);
    if (exp_cnt < 15) exp_cnt++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
    en    = 1'b1;
    ready = 1'b1;
    mask  = '0;
    exp_cnt = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    ready = 1'b1;
    req   = '0;
    mask  = '0;
    #2;
    n_cmp++;
    if ({sel, ack, y_valid, y_ch, overrun, cnt} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_por: got sel=%0d ack=%h yv=%b ych=%0d ovr=%b cnt=%0d expected all 0",
               sel, ack, y_valid, y_ch, overrun, cnt);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    // grant channel 0 with channel 1 left pending, then reset mid-flight
    req = 8'h03;
    tick();
    req = '0;
    tick();
    n_cmp++;
    if (ack !== 8'h01 || cnt !== 4'd1) begin
      n_err++;
      $display("[TB] FAIL reset_pre_grant: got ack=%h cnt=%0d expected ack=01 cnt=1", ack, cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sel, ack, y_valid, y_ch, overrun, cnt} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_async: got sel=%0d ack=%h yv=%b ych=%0d ovr=%b cnt=%0d expected all 0",
               sel, ack, y_valid, y_ch, overrun, cnt);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (ack !== 8'h00 || y_valid !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL reset_no_grant: cycle %0d got ack=%h yv=%b expected ack=00 yv=0", i, ack, y_valid);
      end
    end
    n_cmp++;
    if (cnt !== 4'd0) begin
      n_err++;
      $display("[TB] FAIL reset_cnt: got %0d expected 0", cnt);
    end
  endtask

  task automatic test_single();
    req = 8'h04;
    note_grant(2);
    tick();
    req = '0;
    tick();
    n_cmp++;
    if (sel !== 3'd2 || ack !== 8'h04) begin
      n_err++;
      $display("[TB] FAIL single_grant: got sel=%0d ack=%h expected sel=2 ack=04", sel, ack);
    end
    tick();
    n_cmp++;
    if (y_valid !== 1'b1 || y_ch !== 3'd2 || cnt !== CntW'(exp_cnt)) begin
      n_err++;
      $display("[TB] FAIL single_out: got yv=%b ych=%0d cnt=%0d expected yv=1 ych=2 cnt=%0d",
               y_valid, y_ch, cnt, exp_cnt);
    end
    tick();
    n_cmp++;
    if (ack !== 8'h00 || y_valid !== 1'b0 || sel !== 3'd2) begin
      n_err++;
      $display("[TB] FAIL single_idle: got ack=%h yv=%b sel=%0d expected ack=00 yv=0 sel=2", ack, y_valid, sel);
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    req = 8'hFF;
    for (int i = 0; i < 8; i++) note_grant(i);
    tick();
    req = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (sel !== 3'(i) || ack !== (8'h01 << i)) begin
        n_err++;
        $display("[TB] FAIL fair_order: step %0d got sel=%0d ack=%h expected sel=%0d", i, sel, ack, i);
      end
    end
    tick();
    tick();
    // pointer is back at 0: channel 0 wins before channel 7
    req = 8'h81;
    note_grant(0);
    note_grant(7);
    tick();
    req = '0;
    tick();
    n_cmp++;
    if (ack !== 8'h01) begin
      n_err++;
      $display("[TB] FAIL fair_81_first: got ack=%h expected 01", ack);
    end
    tick();
    n_cmp++;
    if (ack !== 8'h80) begin
      n_err++;
      $display("[TB] FAIL fair_81_second: got ack=%h expected 80", ack);
    end
    tick();
    // move pointer to 7 via a grant to channel 6, then 7 must win before 0
    req = 8'h40;
    note_grant(6);
    tick();
    req = '0;
    tick();
    n_cmp++;
    if (ack !== 8'h40) begin
      n_err++;
      $display("[TB] FAIL fair_ptr7: got ack=%h expected 40", ack);
    end
    req = 8'h81;
    note_grant(7);
    note_grant(0);
    tick();
    req = '0;
    tick();
    n_cmp++;
    if (ack !== 8'h80) begin
      n_err++;
      $display("[TB] FAIL wrap_first: got ack=%h expected 80", ack);
    end
    tick();
    n_cmp++;
    if (ack !== 8'h01) begin
      n_err++;
      $display("[TB] FAIL wrap_second: got ack=%h expected 01", ack);
    end
    tick();
    tick();
    n_cmp++;
    if (exp_q.size() != 0 || cnt !== CntW'(exp_cnt)) begin
      n_err++;
      $display("[TB] FAIL fair_drain: got %0d queued cnt=%0d expected 0 queued cnt=%0d", exp_q.size(), cnt, exp_cnt);
    end
  endtask

  task automatic test_stall_mask();
    ready = 1'b0;
    req   = 8'h30;
    tick();
    req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (ack !== 8'h00) begin
        n_err++;
        $display("[TB] FAIL stall_no_grant: cycle %0d got ack=%h expected 00", i, ack);
      end
    end
    mask  = 8'h10;
    ready = 1'b1;
    note_grant(5);
    tick();
    n_cmp++;
    if (ack !== 8'h20 || sel !== 3'd5) begin
      n_err++;
      $display("[TB] FAIL mask_grant5: got ack=%h sel=%0d expected ack=20 sel=5", ack, sel);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (ack !== 8'h00) begin
        n_err++;
        $display("[TB] FAIL mask_hold: cycle %0d got ack=%h expected 00", i, ack);
      end
    end
    mask = '0;
    note_grant(4);
    tick();
    n_cmp++;
    if (ack !== 8'h10 || sel !== 3'd4) begin
      n_err++;
      $display("[TB] FAIL unmask_grant4: got ack=%h sel=%0d expected ack=10 sel=4", ack, sel);
    end
    tick();
    tick();
    n_cmp++;
    if (exp_q.size() != 0 || cnt !== CntW'(exp_cnt)) begin
      n_err++;
      $display("[TB] FAIL mask_drain: got %0d queued cnt=%0d expected 0 queued cnt=%0d", exp_q.size(), cnt, exp_cnt);
    end
  endtask

  task automatic test_simultaneous();
    req = 8'h08;
    note_grant(3);
    tick();
    // channel 3 is granted at the next edge while it requests again
    req = 8'h08;
    note_grant(3);
    tick();
    req = '0;
    n_cmp++;
    if (ack !== 8'h08) begin
      n_err++;
      $display("[TB] FAIL regrant_first: got ack=%h expected 08", ack);
    end
    tick();
    n_cmp++;
    if (ack !== 8'h08 || overrun !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL regrant_second: got ack=%h ovr=%b expected ack=08 ovr=0", ack, overrun);
    end
    tick();
    n_cmp++;
    if (ack !== 8'h00) begin
      n_err++;
      $display("[TB] FAIL regrant_done: got ack=%h expected 00", ack);
    end
    // second request on a pending, non-granted channel
    ready = 1'b0;
    req   = 8'h02;
    tick();
    req = 8'h02;
    tick();
    req = '0;
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL overrun_pulse: got %b expected 1", overrun);
    end
    tick();
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL overrun_clear: got %b expected 0", overrun);
    end
    ready = 1'b1;
    note_grant(1);
    tick();
    n_cmp++;
    if (ack !== 8'h02) begin
      n_err++;
      $display("[TB] FAIL merged_grant: got ack=%h expected 02", ack);
    end
    tick();
    n_cmp++;
    if (ack !== 8'h00) begin
      n_err++;
      $display("[TB] FAIL merged_once: got ack=%h expected 00", ack);
    end
    tick();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL simul_drain: got %0d queued expected 0", exp_q.size());
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    req = 8'hFF;
    tick();
    for (int g = 0; g < 20; g++) begin
      note_grant(g % 8);
      tick();
      n_cmp++;
      if (ack !== (8'h01 << (g % 8)) || cnt !== CntW'(exp_cnt)) begin
        n_err++;
        $display("[TB] FAIL sat_step: grant %0d got ack=%h cnt=%0d expected ch=%0d cnt=%0d",
                 g, ack, cnt, g % 8, exp_cnt);
      end
    end
    en  = 1'b0;
    req = '0;
    tick();
    tick();
    tick();
    n_cmp++;
    if (cnt !== 4'hF || exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL sat_final: got cnt=%h queued=%0d expected cnt=f queued=0", cnt, exp_q.size());
    end
    apply_reset();
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_stall_mask();
    test_simultaneous();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
